// File: rtl/char_select_menu.sv
// Two-player character select menu: IDLE -> SELECT -> COUNTDOWN -> DONE -> IDLE.
// Optional macro CHAR_SELECT_CANCEL_EN lets a locked player un-lock with Confirm.
module char_select_menu #(
  parameter int NUM_CHARS        = 4,
  parameter int COUNTDOWN_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start_Req,
  input  logic       P1_Left,
  input  logic       P1_Right,
  input  logic       P1_Confirm,
  input  logic       P2_Left,
  input  logic       P2_Right,
  input  logic       P2_Confirm,
  output logic [3:0] Player_One_Char_Num,
  output logic [3:0] Player_Two_Char_Num,
  output logic       P1_Locked,
  output logic       P2_Locked,
  output logic       Menu_Active,
  output logic       Select_Done
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SELECT    = 2'd1;
  localparam logic [1:0] COUNTDOWN = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [3:0] MAX_CHAR = 4'(NUM_CHARS - 1);
  localparam logic [9:0] CNT_LOAD = 10'(COUNTDOWN_CYCLES - 1);

  logic [1:0] state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [3:0] p1_char_n, p2_char_n;
  logic       p1_lock_n, p2_lock_n;
  logic       active_n, done_n;

  logic p1_l_q, p1_r_q, p1_c_q, p2_l_q, p2_r_q, p2_c_q;
  logic p1_l_rise, p1_r_rise, p1_c_rise, p2_l_rise, p2_r_rise, p2_c_rise;

  assign p1_l_rise = P1_Left    & ~p1_l_q;
  assign p1_r_rise = P1_Right   & ~p1_r_q;
  assign p1_c_rise = P1_Confirm & ~p1_c_q;
  assign p2_l_rise = P2_Left    & ~p2_l_q;
  assign p2_r_rise = P2_Right   & ~p2_r_q;
  assign p2_c_rise = P2_Confirm & ~p2_c_q;

  // Left+Right together cancel out; otherwise step with wrap-around.
  function automatic logic [3:0] step_char(input logic [3:0] cur,
                                           input logic       left,
                                           input logic       right);
    logic [3:0] res;
    res = cur;
    if (right && !left)
      res = (cur == MAX_CHAR) ? 4'd0 : cur + 4'd1;
    else if (left && !right)
      res = (cur == 4'd0) ? MAX_CHAR : cur - 4'd1;
    return res;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    p1_char_n = Player_One_Char_Num;
    p2_char_n = Player_Two_Char_Num;
    p1_lock_n = P1_Locked;
    p2_lock_n = P2_Locked;
    active_n  = Menu_Active;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (Start_Req) begin
          state_n   = SELECT;
          p1_lock_n = 1'b0;
          p2_lock_n = 1'b0;
          active_n  = 1'b1;
        end
      end
      SELECT: begin
        if (!P1_Locked) begin
          p1_char_n = step_char(Player_One_Char_Num, p1_l_rise, p1_r_rise);
          if (p1_c_rise) p1_lock_n = 1'b1;
        end
`ifdef CHAR_SELECT_CANCEL_EN
        else if (p1_c_rise) p1_lock_n = 1'b0;
`endif
        if (!P2_Locked) begin
          p2_char_n = step_char(Player_Two_Char_Num, p2_l_rise, p2_r_rise);
          if (p2_c_rise) p2_lock_n = 1'b1;
        end
`ifdef CHAR_SELECT_CANCEL_EN
        else if (p2_c_rise) p2_lock_n = 1'b0;
`endif
        if (p1_lock_n && p2_lock_n) begin
          state_n = COUNTDOWN;
          cnt_n   = CNT_LOAD;
        end
      end
      COUNTDOWN: begin
`ifdef CHAR_SELECT_CANCEL_EN
        if (p1_c_rise || p2_c_rise) begin
          if (p1_c_rise) p1_lock_n = 1'b0;
          if (p2_c_rise) p2_lock_n = 1'b0;
          state_n = SELECT;
          cnt_n   = '0;
        end else
`endif
        if (cnt == '0) begin
          state_n  = DONE;
          done_n   = 1'b1;
          active_n = 1'b0;
        end else begin
          cnt_n = cnt - 10'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      Player_One_Char_Num <= '0;
      Player_Two_Char_Num <= '0;
      P1_Locked           <= 1'b0;
      P2_Locked           <= 1'b0;
      Menu_Active         <= 1'b0;
      Select_Done         <= 1'b0;
      p1_l_q <= 1'b0; p1_r_q <= 1'b0; p1_c_q <= 1'b0;
      p2_l_q <= 1'b0; p2_r_q <= 1'b0; p2_c_q <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      Player_One_Char_Num <= p1_char_n;
      Player_Two_Char_Num <= p2_char_n;
      P1_Locked           <= p1_lock_n;
      P2_Locked           <= p2_lock_n;
      Menu_Active         <= active_n;
      Select_Done         <= done_n;
      p1_l_q <= P1_Left;  p1_r_q <= P1_Right;  p1_c_q <= P1_Confirm;
      p2_l_q <= P2_Left;  p2_r_q <= P2_Right;  p2_c_q <= P2_Confirm;
    end
  end

endmodule

// File: tb/tb_char_select_menu.sv
// Directed bench for char_select_menu with default parameters.
module tb_char_select_menu;

  logic       Clk = 1'b0;
  logic       Reset, Start_Req;
  logic       P1_Left, P1_Right, P1_Confirm, P2_Left, P2_Right, P2_Confirm;
  logic [3:0] p1_num, p2_num;
  logic       p1_lk, p2_lk, active, done;

  int checks   = 0;
  int failures = 0;

  char_select_menu #(.NUM_CHARS(4), .COUNTDOWN_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start_Req(Start_Req),
    .P1_Left(P1_Left), .P1_Right(P1_Right), .P1_Confirm(P1_Confirm),
    .P2_Left(P2_Left), .P2_Right(P2_Right), .P2_Confirm(P2_Confirm),
    .Player_One_Char_Num(p1_num), .Player_Two_Char_Num(p2_num),
    .P1_Locked(p1_lk), .P2_Locked(p2_lk),
    .Menu_Active(active), .Select_Done(done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p1num"}, 32'(p1_num), 0);
    chk({tag, "_p2num"}, 32'(p2_num), 0);
    chk({tag, "_p1lk"},  32'(p1_lk),  0);
    chk({tag, "_p2lk"},  32'(p2_lk),  0);
    chk({tag, "_act"},   32'(active), 0);
    chk({tag, "_done"},  32'(done),   0);
  endtask

  initial begin
    Reset = 1'b1; Start_Req = 1'b0;
    P1_Left = 1'b0; P1_Right = 1'b0; P1_Confirm = 1'b0;
    P2_Left = 1'b0; P2_Right = 1'b0; P2_Confirm = 1'b0;
    step(); step();
    chk_all_zero("reset");
    Reset = 1'b0;
    step();
    chk("idle_inactive", 32'(active), 0);

    Start_Req = 1'b1; step(); Start_Req = 1'b0;
    chk("start_active", 32'(active), 1);
    chk("start_p1lk", 32'(p1_lk), 0);

    // Three P1_Right rises then wrap
    for (int i = 1; i <= 4; i++) begin
      P1_Right = 1'b1; step();
      chk($sformatf("p1_right_%0d", i), 32'(p1_num), (i == 4) ? 0 : i);
      P1_Right = 1'b0; step();
    end

    // P2_Left from 0 wraps to 3, held level counts once
    P2_Left = 1'b1; step();
    chk("p2_left_wrap", 32'(p2_num), 3);
    step(); step(); step(); step();
    chk("p2_left_held", 32'(p2_num), 3);
    P2_Left = 1'b0; step();

    P1_Right = 1'b1; step(); P1_Right = 1'b0; step();
    P1_Right = 1'b1; step(); P1_Right = 1'b0; step();
    chk("p1_at_2", 32'(p1_num), 2);

    P1_Left = 1'b1; P1_Right = 1'b1; P2_Right = 1'b1; step();
    chk("p1_lr_same", 32'(p1_num), 2);
    chk("p2_right_wrap", 32'(p2_num), 0);
    P1_Left = 1'b0; P1_Right = 1'b0; P2_Right = 1'b0; step();

    P1_Confirm = 1'b1; step(); P1_Confirm = 1'b0;
    chk("p1_lock", 32'(p1_lk), 1);
    chk("p2_unlocked", 32'(p2_lk), 0);
    step();
    P1_Right = 1'b1; P2_Right = 1'b1; step();
    chk("p1_locked_ignores", 32'(p1_num), 2);
    chk("p2_right_inc", 32'(p2_num), 1);
    P1_Right = 1'b0; P2_Right = 1'b0; step();

    // P2 confirm completes locking: countdown of 8 cycles
    P2_Confirm = 1'b1; step(); P2_Confirm = 1'b0;
    chk("p2_lock", 32'(p2_lk), 1);
    chk("cd_active", 32'(active), 1);
    P1_Left = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      P1_Left = 1'b0;
      chk($sformatf("cd_done_%0d", i), 32'(done), (i == 8) ? 1 : 0);
    end
    chk("done_inactive", 32'(active), 0);
    chk("cd_left_ignored", 32'(p1_num), 2);
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("hold_p1lk", 32'(p1_lk), 1);
    chk("hold_p2num", 32'(p2_num), 1);

    P1_Right = 1'b1; step(); P1_Right = 1'b0; step();
    chk("idle_key_ignored", 32'(p1_num), 2);

    Start_Req = 1'b1; step(); Start_Req = 1'b0;
    chk("restart_p1lk", 32'(p1_lk), 0);
    chk("restart_p2lk", 32'(p2_lk), 0);
    chk("restart_p1num", 32'(p1_num), 2);

    // Both confirm together, then P1 confirms again at countdown cycle 4
    P1_Confirm = 1'b1; P2_Confirm = 1'b1; step();
    P1_Confirm = 1'b0; P2_Confirm = 1'b0;
    chk("both_lock", 32'(p1_lk & p2_lk), 1);
    step(); step(); step();
    P1_Confirm = 1'b1; step(); P1_Confirm = 1'b0;
`ifdef CHAR_SELECT_CANCEL_EN
    chk("cancel_p1lk", 32'(p1_lk), 0);
    chk("cancel_p2lk", 32'(p2_lk), 1);
    chk("cancel_active", 32'(active), 1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("cancel_nodone_%0d", i), 32'(done), 0);
    end
`else
    chk("nocancel_p1lk", 32'(p1_lk), 1);
    for (int i = 5; i <= 8; i++) begin
      step();
      chk($sformatf("sched_done_%0d", i), 32'(done), (i == 8) ? 1 : 0);
    end
    step();
    chk("sched_done_end", 32'(done), 0);
`endif

    // Reset during countdown
    Reset = 1'b1; step(); Reset = 1'b0;
    Start_Req = 1'b1; step(); Start_Req = 1'b0;
    P1_Right = 1'b1; step(); P1_Right = 1'b0; step();
    chk("pre_rst_p1num", 32'(p1_num), 1);
    P1_Confirm = 1'b1; P2_Confirm = 1'b1; step();
    P1_Confirm = 1'b0; P2_Confirm = 1'b0;
    step(); step(); step(); step();
    Reset = 1'b1; #1;
    chk_all_zero("rst_cd");
    step(); step();
    Reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("rst_nodone_%0d", i), 32'(done), 0);
    end
    chk("rst_inactive", 32'(active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
